gcd_engine: RTL and testbench

//  Parametrised GCD unit: next generation of the GCD datapath/controller pair.
//  - Takes both operands in one valid/ready transfer; subtractive Euclid, one step per clock.
//  - Returns the result through a valid/ready output with backpressure.
//  - Correct zero-operand handling.
//  - Sits between an operand producer and a result consumer, e.g. a host register block.

---
 rtl/gcd_engine_pkg.sv | 20 ++
 rtl/gcd_engine_if.sv | 38 +++
 rtl/gcd_engine_dp.sv | 50 +++++
 rtl/gcd_engine.sv | 122 ++++++++++++
 tb/tb_gcd_engine.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/gcd_engine_pkg.sv
// Shared types for the GCD engine: FSM state encoding, default width and the
// control bundle the FSM hands to the datapath.
package gcd_engine_pkg;

    localparam int GCD_WIDTH = 16;

    typedef enum logic [1:0] {
        GCD_S_IDLE = 2'd0,
        GCD_S_CALC = 2'd1,
        GCD_S_DONE = 2'd2
    } gcd_state_t;

    // sel=0 loads the operand inputs, sel=1 loads the subtractor result
    typedef struct packed {
        logic ld_a;
        logic ld_b;
        logic sel;
    } gcd_dp_ctrl_t;

endpackage

// File: rtl/gcd_engine_if.sv
// Operand/result handshake bundle for gcd_engine.
// iter_count is present only when GCD_ITER_COUNT_EN is defined.
interface gcd_engine_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] gcd_out;
    logic             busy;
`ifdef GCD_ITER_COUNT_EN
    logic [WIDTH-1:0] iter_count;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, gcd_out, busy, iter_count
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, gcd_out, busy, iter_count
    );
`else
    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, gcd_out, busy
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, gcd_out, busy
    );
`endif

endinterface

// File: rtl/gcd_engine_dp.sv
// GCD datapath: A/B operand registers, load muxes, magnitude comparator and a
// single subtractor shared between both registers.
module gcd_engine_dp
    import gcd_engine_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  gcd_dp_ctrl_t     ctrl,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] a_val,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;

    assign gt = (a_reg > b_reg);
    assign lt = (a_reg < b_reg);
    assign eq = (a_reg == b_reg);

    // Larger minus smaller, so the difference never underflows
    assign diff   = gt ? (a_reg - b_reg) : (b_reg - a_reg);
    assign a_next = ctrl.sel ? diff : a_in;
    assign b_next = ctrl.sel ? diff : b_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            if (ctrl.ld_a) begin
                a_reg <= a_next;
            end
            if (ctrl.ld_b) begin
                b_reg <= b_next;
            end
        end
    end

    assign a_val = a_reg;

endmodule

// File: rtl/gcd_engine.sv
// Subtractive-Euclid GCD engine with valid/ready operand and result ports.
// Define GCD_ITER_COUNT_EN to add the iter_count port and CALC-cycle counter.
module gcd_engine
    import gcd_engine_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    gcd_engine_if.slave bus
);

    gcd_state_t       state_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             busy_reg;
    logic [WIDTH-1:0] gcd_reg;
`ifdef GCD_ITER_COUNT_EN
    logic [WIDTH-1:0] iter_reg;
`endif

    logic [WIDTH-1:0] a_val;
    logic             gt;
    logic             lt;
    logic             eq;
    logic             accept;
    logic             in_calc;
    logic             zero_op;
    gcd_dp_ctrl_t     dp_ctrl;

    assign accept  = (state_reg == GCD_S_IDLE) && bus.in_valid;
    assign in_calc = (state_reg == GCD_S_CALC);
    assign zero_op = (bus.a_in == '0) || (bus.b_in == '0);

    always_comb begin
        dp_ctrl      = '0;
        dp_ctrl.sel  = in_calc;
        dp_ctrl.ld_a = accept || (in_calc && gt);
        dp_ctrl.ld_b = accept || (in_calc && lt);
    end

    gcd_engine_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk   (clk),
        .rst   (rst),
        .ctrl  (dp_ctrl),
        .a_in  (bus.a_in),
        .b_in  (bus.b_in),
        .a_val (a_val),
        .gt    (gt),
        .lt    (lt),
        .eq    (eq)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= GCD_S_IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            gcd_reg       <= '0;
`ifdef GCD_ITER_COUNT_EN
            iter_reg      <= '0;
`endif
        end else begin
            case (state_reg)
                GCD_S_IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
`ifdef GCD_ITER_COUNT_EN
                        iter_reg     <= '0;
`endif
                        // A zero operand short-circuits: gcd(x,0)=x, gcd(0,0)=0
                        if (zero_op) begin
                            gcd_reg       <= bus.a_in | bus.b_in;
                            out_valid_reg <= 1'b1;
                            state_reg     <= GCD_S_DONE;
                        end else begin
                            state_reg     <= GCD_S_CALC;
                        end
                    end
                end
                GCD_S_CALC: begin
`ifdef GCD_ITER_COUNT_EN
                    iter_reg <= iter_reg + WIDTH'(1);
`endif
                    if (eq) begin
                        gcd_reg       <= a_val;
                        out_valid_reg <= 1'b1;
                        state_reg     <= GCD_S_DONE;
                    end
                end
                GCD_S_DONE: begin
                    // in_ready stays low here so a result is never overlapped by a new accept
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= GCD_S_IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= GCD_S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.gcd_out   = gcd_reg;
`ifdef GCD_ITER_COUNT_EN
    assign bus.iter_count = iter_reg;
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// Directed plus randomized scoreboard bench for gcd_engine (WIDTH=16);
// iter_count checks are compiled in when GCD_ITER_COUNT_EN is defined.
module tb_gcd_engine;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gcd_engine_if #(.WIDTH(W)) bus();

    gcd_engine #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] g;
        logic [W-1:0] it;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   lat   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [W-1:0] ref_iter(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y;
        int n;
        if (a == 0 || b == 0) return '0;
        x = a;
        y = b;
        n = 1;
        while (x != y) begin
            if (x > y) x = x - y;
            else       y = y - x;
            n++;
        end
        return W'(n);
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the accept edge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] g, input logic [W-1:0] it);
        int   n;
        exp_t e;
        n = 0;
        bus.a_in     = a;
        bus.b_in     = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        e.a = a; e.b = b; e.g = g; e.it = it;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic receive(input int stall, input bit hold_ready, input bit rnd, input int budget);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.out_valid && n < budget) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : hold_ready;
            @(posedge clk); #1;
            n++;
        end
        lat = n + 1;
        check("out_valid_seen", 32'(bus.out_valid), 32'd1);
        check("sb_pending", 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        if (!bus.out_valid) return;
        for (int i = 0; i < stall; i++) begin
            bus.out_ready = 1'b0;
            @(posedge clk); #1;
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_gcd",       32'(bus.gcd_out),   32'(e.g));
            check("hold_in_ready",  32'(bus.in_ready),  32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("gcd", 32'(bus.gcd_out), 32'(e.g));
`ifdef GCD_ITER_COUNT_EN
        check("iter", 32'(bus.iter_count), 32'(e.it));
`endif
        $display("[TB] txn a=%0d b=%0d gcd=%0d expected=%0d latency=%0d",
                 e.a, e.b, bus.gcd_out, e.g, lat);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("out_valid_clear", 32'(bus.out_valid), 32'd0);
        check("in_ready_back",   32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;

        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_gcd",       32'(bus.gcd_out),   32'd0);
`ifdef GCD_ITER_COUNT_EN
        check("rst_iter",      32'(bus.iter_count), 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Main case with latency
        send(16'd143, 16'd78, 16'd13, 16'd7);
        check("busy_calc", 32'(bus.busy), 32'd1);
        receive(0, 1'b1, 1'b0, 50);
        check("lat_143_78", 32'(lat), 32'd8);

        // Zero operands and trivial cases
        send(16'd0, 16'd25, 16'd25, 16'd0);
        receive(0, 1'b0, 1'b0, 50);
        check("lat_0_25", 32'(lat), 32'd1);
        send(16'd25, 16'd0, 16'd25, 16'd0);
        receive(0, 1'b0, 1'b0, 50);
        check("lat_25_0", 32'(lat), 32'd1);
        send(16'd0, 16'd0, 16'd0, 16'd0);
        receive(0, 1'b0, 1'b0, 50);
        check("lat_0_0", 32'(lat), 32'd1);
        send(16'd12, 16'd12, 16'd12, 16'd1);
        receive(0, 1'b0, 1'b0, 50);
        check("lat_12_12", 32'(lat), 32'd2);

        // Worst case
        send(16'd1, 16'd65535, 16'd1, 16'd65535);
        receive(0, 1'b0, 1'b0, 70000);
        check("lat_1_65535", 32'(lat), 32'd65536);

        // Backpressure with a competing request that must be ignored
        send(16'd48, 16'd18, 16'd6, 16'd4);
        bus.a_in     = 16'd99;
        bus.b_in     = 16'd33;
        bus.in_valid = 1'b1;
        receive(20, 1'b0, 1'b0, 50);
        @(posedge clk); #1;
        check("bp_no_accept_valid", 32'(bus.out_valid), 32'd0);
        check("bp_no_accept_busy",  32'(bus.busy),      32'd0);

        // Reset in the middle of a calculation
        send(16'd143, 16'd78, 16'd13, 16'd7);
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_gcd",       32'(bus.gcd_out),   32'd0);
        check("mid_rst_busy",      32'(bus.busy),      32'd0);
        void'(sb.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        send(16'd35, 16'd21, 16'd7, 16'd4);
        receive(0, 1'b0, 1'b0, 50);

        // Randomized back-to-back with stalls
        for (int k = 0; k < 50; k++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(1, 255));
            if ($urandom_range(0, 7) == 0) ra = '0;
            send(ra, rb, ref_gcd(ra, rb), ref_iter(ra, rb));
            receive($urandom_range(0, 3), 1'b0, 1'b1, 2000);
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
